// File: rtl/boton_ar_multicanal.sv
// boton_ar_multicanal: N-channel button debouncer with press/release/long-press pulses
module boton_ar_multicanal #(
  parameter int N_BOTONES      = 4,
  parameter int CICLOS_ESTABLE = 16,
  parameter int CICLOS_LARGO   = 100,
  parameter bit ACTIVO_BAJO    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BOTONES-1:0] boton_in,
  output logic [N_BOTONES-1:0] boton_out,
  output logic [N_BOTONES-1:0] pulso_presion,
  output logic [N_BOTONES-1:0] pulso_suelta,
  output logic [N_BOTONES-1:0] pulso_largo
);
  localparam int CW = $clog2(CICLOS_ESTABLE + 1);
  localparam int LW = $clog2(CICLOS_LARGO + 1);
  logic [N_BOTONES-1:0] sync_a, s;
  always_ff @(posedge clk)
    if (reset) begin
      sync_a <= '0;
      s      <= '0;
    end else begin
      sync_a <= boton_in ^ {N_BOTONES{ACTIVO_BAJO}};
      s      <= sync_a;
    end
  for (genvar g = 0; g < N_BOTONES; g++) begin : g_canal
    logic [CW-1:0] cnt;
    logic [LW-1:0] hold;
    logic          lvl, pp, ps, pl, fin;
    assign fin = (s[g] != lvl) && (cnt == CW'(CICLOS_ESTABLE - 1));
    always_ff @(posedge clk)
      if (reset) begin
        cnt  <= '0;
        hold <= '0;
        lvl  <= 1'b0;
        pp   <= 1'b0;
        ps   <= 1'b0;
        pl   <= 1'b0;
      end else begin
        cnt  <= (s[g] == lvl || fin) ? '0 : cnt + CW'(1);
        lvl  <= fin ? s[g] : lvl;
        pp   <= fin && s[g];
        ps   <= fin && !s[g];
        hold <= !lvl ? '0 : (hold == LW'(CICLOS_LARGO)) ? hold : hold + LW'(1);
        pl   <= lvl && (hold == LW'(CICLOS_LARGO - 1));
      end
    assign boton_out[g]     = lvl;
    assign pulso_presion[g] = pp;
    assign pulso_suelta[g]  = ps;
    assign pulso_largo[g]   = pl;
  end
endmodule

// File: tb/tb_boton_ar_multicanal.sv
// tb_boton_ar_multicanal: scoreboard bench for the multichannel debouncer
module tb_boton_ar_multicanal;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] boton_in = '0;
  logic [3:0] boton_out, pulso_presion, pulso_suelta, pulso_largo;
  logic [3:0] in_ab = 4'hF;
  logic [3:0] out_ab, pp_ab, ps_ab, pl_ab;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  typedef struct {int t; int ch; int kind;} ev_t;
  ev_t        q[$];
  logic [3:0] lvl = '0;
  logic [3:0] ep, es, el;
  logic [3:0] v;
  int         k;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  boton_ar_multicanal #(.N_BOTONES(4), .CICLOS_ESTABLE(4), .CICLOS_LARGO(20), .ACTIVO_BAJO(1'b0)) dut (
    .clk(clk), .reset(reset), .boton_in(boton_in), .boton_out(boton_out),
    .pulso_presion(pulso_presion), .pulso_suelta(pulso_suelta), .pulso_largo(pulso_largo)
  );
  boton_ar_multicanal #(.N_BOTONES(4), .CICLOS_ESTABLE(4), .CICLOS_LARGO(20), .ACTIVO_BAJO(1'b1)) u_ab (
    .clk(clk), .reset(reset), .boton_in(in_ab), .boton_out(out_ab),
    .pulso_presion(pp_ab), .pulso_suelta(ps_ab), .pulso_largo(pl_ab)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask
  // kind: 0 press, 1 release, 2 long press, 3 level dropped by reset (no pulse)
  task automatic push(input int t, input int ch, input int kind);
    q.push_back('{t, ch, kind});
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk)
    if (mon_en) begin
      ep = '0;
      es = '0;
      el = '0;
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].t == cyc) begin
          case (q[i].kind)
            0: begin ep[q[i].ch] = 1'b1; lvl[q[i].ch] = 1'b1; end
            1: begin es[q[i].ch] = 1'b1; lvl[q[i].ch] = 1'b0; end
            2: el[q[i].ch] = 1'b1;
            default: lvl[q[i].ch] = 1'b0;
          endcase
          q.delete(i);
        end
      chk("boton_out", boton_out, lvl);
      chk("pulso_presion", pulso_presion, ep);
      chk("pulso_suelta", pulso_suelta, es);
      chk("pulso_largo", pulso_largo, el);
    end
  initial begin
    step(1);
    mon_en = 1'b1;
    // reset held with random inputs; outputs must stay 0
    repeat (5) begin
      boton_in = 4'($urandom);
      step(1);
    end
    chk("ab_reset", {pl_ab, ps_ab, pp_ab, out_ab}, 32'h0);
    v = 4'($urandom_range(1, 15));
    boton_in = v;
    reset = 1'b0;
    for (int b = 0; b < 4; b++) if (v[b]) push(cyc + 6, b, 0);
    step(8);
    boton_in = '0;
    for (int b = 0; b < 4; b++) if (v[b]) push(cyc + 6, b, 1);
    step(10);
    chk("ab_idle", {pl_ab, ps_ab, pp_ab, out_ab}, 32'h0);
    // clean press on ch0, plus active-low instance bit0
    k = cyc;
    boton_in[0] = 1'b1;
    in_ab[0] = 1'b0;
    push(k + 6, 0, 0);
    step(5);
    chk("ab_before", out_ab, 4'h0);
    step(1);
    chk("ab_out", out_ab, 4'h1);
    chk("ab_presion", pp_ab, 4'h1);
    step(4);
    boton_in[0] = 1'b0;
    push(cyc + 6, 0, 1);
    step(10);
    // bouncing ch1 never propagates
    for (int i = 0; i < 15; i++) begin
      boton_in[1] = ~boton_in[1];
      step(2);
    end
    boton_in[1] = 1'b0;
    step(8);
    // long hold on ch2
    k = cyc;
    boton_in[2] = 1'b1;
    push(k + 6, 2, 0);
    push(k + 26, 2, 2);
    step(40);
    boton_in[2] = 1'b0;
    push(cyc + 6, 2, 1);
    step(10);
    // 15-cycle hold: no long press
    k = cyc;
    boton_in[2] = 1'b1;
    push(k + 6, 2, 0);
    step(15);
    boton_in[2] = 1'b0;
    push(cyc + 6, 2, 1);
    step(10);
    // all channels simultaneously
    boton_in = 4'hF;
    for (int b = 0; b < 4; b++) push(cyc + 6, b, 0);
    step(8);
    boton_in = 4'h0;
    for (int b = 0; b < 4; b++) push(cyc + 6, b, 1);
    step(10);
    // reset pulse during ch3 press
    k = cyc;
    boton_in[3] = 1'b1;
    push(k + 6, 3, 0);
    step(8);
    reset = 1'b1;
    push(cyc + 1, 3, 3);
    step(1);
    reset = 1'b0;
    push(cyc + 6, 3, 0);
    step(8);
    boton_in[3] = 1'b0;
    push(cyc + 6, 3, 1);
    step(10);
    mon_en = 1'b0;
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
